// File: rtl/rr_decode_arbiter_if.sv
// Bundle carrying the requester-side inputs and grant-side outputs of rr_decode_arbiter.
// The master modport is the arbiter. The slave modport is the requester/consumer side.
interface rr_decode_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [15:0]      req;
  logic             gnt_valid;
  logic [3:0]       gnt_idx;
  logic [15:0]      gnt_onehot;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;

  modport master (
    input  en, req,
    output gnt_valid, gnt_idx, gnt_onehot, hold_cnt, timeout
  );

  modport slave (
    output en, req,
    input  gnt_valid, gnt_idx, gnt_onehot, hold_cnt, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// 16-way round-robin arbiter with a hold limit: grant visible one cycle after the IDLE sample,
// followed by one GAP cycle after each owner. There is no backpressure; requesters keep req high to hold the grant.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_decode_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state_q;
  logic [3:0]       ptr_q;
  logic             gnt_valid_q;
  logic [3:0]       gnt_idx_q;
  logic [15:0]      gnt_onehot_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  logic             win_found;
  logic [3:0]       win_idx;
  logic [3:0]       probe;

  // Walk from the farthest offset back to ptr so the closest set bit is kept.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    probe     = ptr_q;
    for (int k = 15; k >= 0; k--) begin
      probe = ptr_q + 4'(k);
      if (bus.req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 4'd0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= 4'd0;
      gnt_onehot_q <= 16'd0;
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en && win_found) begin
            state_q      <= GRANT;
            gnt_valid_q  <= 1'b1;
            gnt_idx_q    <= win_idx;
            gnt_onehot_q <= 16'd1 << win_idx;
            hold_cnt_q   <= CNT_W'(1);
          end
        end
        GRANT: begin
          // Release beats revoke: timeout only flags a grant still being requested.
          if (!bus.req[gnt_idx_q] || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
            state_q      <= GAP;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= 16'd0;
            hold_cnt_q   <= '0;
            ptr_q        <= gnt_idx_q + 4'd1;
            timeout_q    <= bus.req[gnt_idx_q];
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.hold_cnt   = hold_cnt_q;
  assign bus.timeout    = timeout_q;

endmodule
